// File: rtl/dmem_arbiter_if.sv
// Requester A/B and memory-macro signal bundle for the data-memory arbiter.
// slave = arbiter side; master = requesters plus memory model side.
interface dmem_arbiter_if;
  logic        req_a;
  logic        we_a;
  logic [7:0]  addr_a;
  logic [15:0] wdata_a;
  logic        gnt_a;
  logic        rvalid_a;
  logic [15:0] rdata_a;

  logic        req_b;
  logic        we_b;
  logic [7:0]  addr_b;
  logic [15:0] wdata_b;
  logic        gnt_b;
  logic        rvalid_b;
  logic [15:0] rdata_b;

  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    output gnt_a, rvalid_a, rdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_b, rvalid_b, rdata_b,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    input  gnt_a, rvalid_a, rdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_b, rvalid_b, rdata_b,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port sync-read 256x16 memory: fixed priority to A,
// starvation counter promotes B; 1-cycle read return with per-port valid; conflict counter.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             rd_a_q, rd_a_d;
  logic             rd_b_q, rd_b_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  logic b_prio;
  logic both_req;
  logic gnt_a;
  logic gnt_b;

  // Grant decision; everything is suppressed while reset is held.
  always_comb begin
    b_prio   = (wait_cnt_q >= MaxWait);
    both_req = bus.req_a & bus.req_b;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    if (!rst) begin
      if (bus.req_b && (!bus.req_a || b_prio)) begin
        gnt_b = 1'b1;
      end else if (bus.req_a) begin
        gnt_a = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_en    = gnt_a | gnt_b;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 16'h0000;
    if (gnt_a) begin
      bus.mem_we    = bus.we_a;
      bus.mem_addr  = bus.addr_a;
      bus.mem_wdata = bus.wdata_a;
    end else if (gnt_b) begin
      bus.mem_we    = bus.we_b;
      bus.mem_addr  = bus.addr_b;
      bus.mem_wdata = bus.wdata_b;
    end
  end

  always_comb begin
    rd_a_d     = gnt_a & ~bus.we_a;
    rd_b_d     = gnt_b & ~bus.we_b;
    wait_cnt_d = wait_cnt_q;
    if (gnt_b) begin
      wait_cnt_d = 4'd0;
    end else if (bus.req_b && (wait_cnt_q != 4'hF)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    conflict_d = conflict_q;
    if (both_req && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_d = conflict_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      rd_a_q     <= 1'b0;
      rd_b_q     <= 1'b0;
      conflict_q <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      conflict_q <= conflict_d;
    end
  end

  // The read tag steers the shared memory data to exactly one port.
  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rd_a_q;
  assign bus.rvalid_b = rd_b_q;
  assign bus.rdata_a  = rd_a_q ? bus.mem_rdata : 16'h0000;
  assign bus.rdata_b  = rd_b_q ? bus.mem_rdata : 16'h0000;
  assign conflict_cnt = conflict_q;

  a_onehot_gnt : assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench: MAX_WAIT=4 instance with a memory model, MAX_WAIT=0 instance for grant checks.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus0 ();
  logic [15:0] cc;
  logic [15:0] cc0;

  dmem_arbiter #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .conflict_cnt(cc));
  dmem_arbiter #(.MAX_WAIT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .conflict_cnt(cc0));

  logic [15:0] mem [256];
  logic [15:0] mem_q = 16'h0000;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata  = mem_q;
  assign bus0.mem_rdata = 16'h0000;

  typedef struct {
    logic        ra, wa; logic [7:0] aa; logic [15:0] da;
    logic        rb, wb; logic [7:0] ab; logic [15:0] db;
    logic        ga, gb;
    logic        va; logic [15:0] qa;
    logic        vb; logic [15:0] qb;
    logic        men; logic [7:0] maddr;
    logic [15:0] ecc;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ra, input logic wa, input logic [7:0] aa, input logic [15:0] da,
    input logic rb, input logic wb, input logic [7:0] ab, input logic [15:0] db,
    input logic ga, input logic gb, input logic va, input logic [15:0] qa,
    input logic vb, input logic [15:0] qb, input logic [15:0] ecc);
    vec_t x;
    x.ra = ra; x.wa = wa; x.aa = aa; x.da = da;
    x.rb = rb; x.wb = wb; x.ab = ab; x.db = db;
    x.ga = ga; x.gb = gb; x.va = va; x.qa = qa; x.vb = vb; x.qb = qb;
    x.men = ga | gb;
    x.maddr = ga ? aa : (gb ? ab : 8'h00);
    x.ecc = ecc;
    return x;
  endfunction

  task automatic drv(input vec_t x);
    bus.req_a = x.ra; bus.we_a = x.wa; bus.addr_a = x.aa; bus.wdata_a = x.da;
    bus.req_b = x.rb; bus.we_b = x.wb; bus.addr_b = x.ab; bus.wdata_b = x.db;
  endtask

  task automatic drv0(input logic ra, input logic rb);
    bus0.req_a = ra; bus0.we_a = 1'b0; bus0.addr_a = 8'h11; bus0.wdata_a = 16'h0;
    bus0.req_b = rb; bus0.we_b = 1'b0; bus0.addr_b = 8'h22; bus0.wdata_b = 16'h0;
  endtask

  initial begin
    string pat;
    vec_t idle;
    pat = "AAAABAAAAB";
    idle = mk(0,0,8'h00,16'h0, 0,0,8'h00,16'h0, 0,0, 0,16'h0, 0,16'h0, 16'd0);
    rst = 1'b1;
    drv(idle);
    drv0(1'b0, 1'b0);

    // Reset state: request during reset must not be granted.
    #2;
    bus.req_a = 1'b1;
    bus0.req_b = 1'b1;
    @(negedge clk);
    chk("rst gnt_a", bus.gnt_a, 0);
    chk("rst mem_en", bus.mem_en, 0);
    chk("rst gnt_b0", bus0.gnt_b, 0);
    chk("rst rvalid_a", bus.rvalid_a, 0);
    chk("rst rdata_a", bus.rdata_a, 0);
    chk("rst cc", cc, 0);
    drv(idle);
    drv0(1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    //          ra wa aa     da        rb wb ab     db        ga gb va qa        vb qb        cc
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(1,1,8'h10,16'h1234, 0,0,8'h00,16'h0000, 1,0, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 1,0, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0, 1,16'h1234, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,8'h20,16'hBEEF, 0,1, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 0,1, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0, 0,16'h0000, 1,16'hBEEF, 16'd0));
    vecs.push_back(mk(1,1,8'h01,16'h0A0A, 0,0,8'h00,16'h0000, 1,0, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,1,8'h02,16'h0B0B, 0,1, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(1,0,8'h01,16'h0000, 0,0,8'h00,16'h0000, 1,0, 0,16'h0000, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h02,16'h0000, 0,1, 1,16'h0A0A, 0,16'h0000, 16'd0));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0, 0,16'h0000, 1,16'h0B0B, 16'd0));
    // Contention: both read continuously, expected winner sequence in pat.
    for (int j = 0; j < 10; j++) begin
      logic pb, prev_a, prev_b;
      pb     = (pat[j] == "B");
      prev_a = (j > 0) && (pat[j-1] == "A");
      prev_b = (j > 0) && (pat[j-1] == "B");
      vecs.push_back(mk(1,0,8'h01,16'h0, 1,0,8'h02,16'h0, !pb, pb,
                        prev_a, prev_a ? 16'h0A0A : 16'h0,
                        prev_b, prev_b ? 16'h0B0B : 16'h0, 16'(j)));
    end
    vecs.push_back(mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0, 0,16'h0000, 1,16'h0B0B, 16'd10));
    vecs.push_back(mk(1,0,8'h01,16'h0000, 1,0,8'h02,16'h0000, 1,0, 0,16'h0000, 0,16'h0000, 16'd10));
    vecs.push_back(mk(0,0,8'h00,16'h0000, 1,0,8'h02,16'h0000, 0,1, 1,16'h0A0A, 0,16'h0000, 16'd11));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1 drv(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d gnt_a", i), bus.gnt_a, vecs[i].ga);
      chk($sformatf("row%0d gnt_b", i), bus.gnt_b, vecs[i].gb);
      chk($sformatf("row%0d rvalid_a", i), bus.rvalid_a, vecs[i].va);
      chk($sformatf("row%0d rdata_a", i), bus.rdata_a, vecs[i].qa);
      chk($sformatf("row%0d rvalid_b", i), bus.rvalid_b, vecs[i].vb);
      chk($sformatf("row%0d rdata_b", i), bus.rdata_b, vecs[i].qb);
      chk($sformatf("row%0d mem_en", i), bus.mem_en, vecs[i].men);
      chk($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].maddr);
      chk($sformatf("row%0d conflict_cnt", i), cc, vecs[i].ecc);
    end
    @(posedge clk); #1 drv(idle);
    @(negedge clk);
    chk("post rvalid_b", bus.rvalid_b, 1);
    chk("post rdata_b", bus.rdata_b, 16'h0A0A ^ 16'h0101);

    // MAX_WAIT=0: B wins every cycle while both request.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 drv0(1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("mw0 c%0d gnt_b", k), bus0.gnt_b, 1);
      chk($sformatf("mw0 c%0d gnt_a", k), bus0.gnt_a, 0);
    end
    @(posedge clk); #1 drv0(1'b1, 1'b0);
    @(negedge clk);
    chk("mw0 solo gnt_a", bus0.gnt_a, 1);
    chk("mw0 cc", cc0, 6);
    @(posedge clk); #1 drv0(1'b0, 1'b0);

    // Reset asserted the cycle after an A read grant.
    @(posedge clk); #1 drv(mk(1,0,8'h10,16'h0, 1,0,8'h20,16'h0, 0,0, 0,16'h0, 0,16'h0, 16'd0));
    @(negedge clk);
    chk("mid gnt_a", bus.gnt_a, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid rst rvalid_a", bus.rvalid_a, 0);
    chk("mid rst rdata_a", bus.rdata_a, 0);
    chk("mid rst gnt_a", bus.gnt_a, 0);
    chk("mid rst gnt_b", bus.gnt_b, 0);
    chk("mid rst mem_en", bus.mem_en, 0);
    chk("mid rst mem_addr", bus.mem_addr, 0);
    chk("mid rst cc", cc, 0);
    @(posedge clk); #1 drv(idle);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel rvalid_a", bus.rvalid_a, 0);
    chk("rel rdata_a", bus.rdata_a, 0);
    chk("rel rvalid_b", bus.rvalid_b, 0);
    chk("rel cc", cc, 0);
    chk("rel cc0", cc0, 0);
    @(negedge clk);
    chk("rel2 rvalid_a", bus.rvalid_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
